seq_detect_ctrl: RTL and testbench

- Run controller for a programmable serial sequence detector.
- Software programs a pattern, its length, an overlap mode and a match target, then pulses start.
- The block arms the detector, consumes bits under a valid/ready handshake, and raises a Mealy match pulse on each detection.
- It counts matches and finishes with a done pulse. It sits between a bit-stream source and the status/interrupt logic.

---
 rtl/seq_detect_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run controller for a programmable serial sequence detector.
// Latches a pattern/length/overlap/target on start, arms a shift-register
// history, consumes bits under valid/ready, raises a Mealy match pulse per
// detection, counts matches and ends the run with a one-cycle done pulse.
module seq_detect_ctrl #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic [CNT_W-1:0]   cfg_target_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               d_i,
  input  logic               d_valid_i,
  output logic               d_ready_o,
  output logic               match_o,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t state_r, state_s;

  // Latched run configuration
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic [CNT_W-1:0]   tgt_r;

  // Detector datapath; only MAX_LEN-1 past bits are needed because the
  // current bit completes the compare window.
  logic [MAX_LEN-2:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               err_r;

  // Registered status flags, decoded from the next state
  logic ready_r, busy_r, done_r;

  logic               len_ok_s;
  logic               xfer_s;
  logic [MAX_LEN-1:0] win_s;
  logic [MAX_LEN-1:0] mask_s;
  logic [LEN_W:0]     fill_inc_s;
  logic               fill_ok_s;
  logic [LEN_W-1:0]   fill_next_s;
  logic               match_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               hit_s;
  logic               load_s;
  logic               bad_s;

  // Detection datapath: transfer qualification, window compare, counter math
  always_comb begin
    len_ok_s   = (cfg_len_i != {LEN_W{1'b0}}) && (cfg_len_i <= MAX_LEN_L);
    // Abort wins over a simultaneous bit: the bit is not consumed.
    xfer_s     = (state_r == ST_RUN) && d_valid_i && !abort_i;
    win_s      = {hist_r, d_i};
    mask_s     = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (i < int'(len_r));
    end
    fill_inc_s = {1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1};
    fill_ok_s  = (fill_inc_s >= {1'b0, len_r});
    if (fill_inc_s > {1'b0, MAX_LEN_L}) begin
      fill_next_s = MAX_LEN_L;
    end else begin
      fill_next_s = fill_inc_s[LEN_W-1:0];
    end
    match_s    = xfer_s && fill_ok_s && ((win_s & mask_s) == (pat_r & mask_s));
    if (cnt_r == CNT_MAX) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    hit_s      = match_s && (tgt_r != {CNT_W{1'b0}}) && (cnt_inc_s == tgt_r);
  end

  // Next-state logic and run-start decode
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    bad_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (len_ok_s) begin
            load_s  = 1'b1;
            state_s = ST_ARM;
          end else begin
            bad_s   = 1'b1;
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (abort_i) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i || hit_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered status flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == ST_RUN);
      busy_r  <= (state_s == ST_ARM) || (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Config latch, history shift, fill tracking, match counter and error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pat_r  <= {MAX_LEN{1'b0}};
      len_r  <= {LEN_W{1'b0}};
      ovl_r  <= 1'b0;
      tgt_r  <= {CNT_W{1'b0}};
      hist_r <= {(MAX_LEN-1){1'b0}};
      fill_r <= {LEN_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      err_r  <= 1'b0;
    end else if (load_s) begin
      pat_r  <= cfg_pattern_i;
      len_r  <= cfg_len_i;
      ovl_r  <= cfg_overlap_i;
      tgt_r  <= cfg_target_i;
      hist_r <= {(MAX_LEN-1){1'b0}};
      fill_r <= {LEN_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      err_r  <= 1'b0;
    end else if (bad_s) begin
      cnt_r  <= {CNT_W{1'b0}};
      err_r  <= 1'b1;
    end else if (xfer_s) begin
      hist_r <= win_s[MAX_LEN-2:0];
      if (match_s) begin
        cnt_r <= cnt_inc_s;
        // Non-overlapping mode: matched bits may not seed the next match.
        if (ovl_r) begin
          fill_r <= fill_next_s;
        end else begin
          fill_r <= {LEN_W{1'b0}};
        end
      end else begin
        fill_r <= fill_next_s;
      end
    end else begin
      hist_r <= hist_r;
    end
  end

  assign d_ready_o   = ready_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign err_o       = err_r;
  assign match_cnt_o = cnt_r;
  assign match_o     = match_s;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: inputs change 1 time unit after the
// rising edge, outputs are sampled 2 time units after the rising edge.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk_i;
  logic               rst_ni;
  logic [MAX_LEN-1:0] cfg_pattern_i;
  logic [LEN_W-1:0]   cfg_len_i;
  logic               cfg_overlap_i;
  logic [CNT_W-1:0]   cfg_target_i;
  logic               start_i;
  logic               abort_i;
  logic               d_i;
  logic               d_valid_i;
  logic               d_ready_o;
  logic               match_o;
  logic [CNT_W-1:0]   match_cnt_o;
  logic               busy_o;
  logic               done_o;
  logic               err_o;

  int vec_cnt;
  int miss_cnt;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cfg_pattern_i (cfg_pattern_i),
    .cfg_len_i     (cfg_len_i),
    .cfg_overlap_i (cfg_overlap_i),
    .cfg_target_i  (cfg_target_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .d_i           (d_i),
    .d_valid_i     (d_valid_i),
    .d_ready_o     (d_ready_o),
    .match_o       (match_o),
    .match_cnt_o   (match_cnt_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, actual=running required=finished");
    $fatal(1);
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a start request; on return the DUT has taken the start edge.
  task automatic do_start(input logic [7:0] pat, input logic [3:0] len,
                          input logic ovl, input logic [7:0] tgt);
    cfg_pattern_i = pat;
    cfg_len_i     = len;
    cfg_overlap_i = ovl;
    cfg_target_i  = tgt;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #1;
    vec_cnt++;
    if ({d_ready_o, match_o, busy_o, done_o, err_o} !== 5'b00000) begin
      miss_cnt++;
      $display("FAIL reset_flags: actual=%b required=00000",
               {d_ready_o, match_o, busy_o, done_o, err_o});
    end
    vec_cnt++;
    if (match_cnt_o !== 8'd0) begin
      miss_cnt++;
      $display("FAIL reset_cnt: actual=%0d required=0", match_cnt_o);
    end
  endtask

  // Run 8 bits through pattern 101 and abort; exp holds expected match per bit.
  task automatic test_stream(input logic ovl, input logic [7:0] exp,
                             input logic [7:0] exp_cnt);
    logic [7:0] bits;
    bits = 8'b1010_1101;  // sent MSB first: 1,0,1,0,1,1,0,1
    do_start(8'b0000_0101, 4'd3, ovl, 8'd0);
    vec_cnt++;
    if ({busy_o, d_ready_o} !== 2'b10) begin
      miss_cnt++;
      $display("FAIL arm_flags ovl=%0b: actual=%b required=10", ovl, {busy_o, d_ready_o});
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      d_i       = bits[7-i];
      d_valid_i = 1'b1;
      #1;
      vec_cnt++;
      if ({d_ready_o, match_o} !== {1'b1, exp[7-i]}) begin
        miss_cnt++;
        $display("FAIL stream_bit%0d ovl=%0b: actual ready,match=%b required=%b",
                 i + 1, ovl, {d_ready_o, match_o}, {1'b1, exp[7-i]});
      end
      tick();
    end
    d_valid_i = 1'b1;
    d_i       = 1'b1;
    abort_i   = 1'b1;
    #1;
    vec_cnt++;
    if (match_o !== 1'b0) begin
      miss_cnt++;
      $display("FAIL abort_match ovl=%0b: actual=%b required=0", ovl, match_o);
    end
    tick();
    abort_i   = 1'b0;
    d_valid_i = 1'b0;
    #1;
    vec_cnt++;
    if ({done_o, busy_o, d_ready_o, match_cnt_o} !== {3'b100, exp_cnt}) begin
      miss_cnt++;
      $display("FAIL abort_done ovl=%0b: actual done,busy,ready=%b cnt=%0d required 100 cnt=%0d",
               ovl, {done_o, busy_o, d_ready_o}, match_cnt_o, exp_cnt);
    end
    tick();
    #1;
    vec_cnt++;
    if ({done_o, match_cnt_o} !== {1'b0, exp_cnt}) begin
      miss_cnt++;
      $display("FAIL idle_hold ovl=%0b: actual done=%b cnt=%0d required done=0 cnt=%0d",
               ovl, done_o, match_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_target();
    logic [4:0] bits;
    bits = 5'b10101;
    do_start(8'b0000_0101, 4'd3, 1'b1, 8'd2);
    tick();
    for (int i = 0; i < 5; i++) begin
      d_i       = bits[4-i];
      d_valid_i = 1'b1;
      tick();
    end
    #1;
    vec_cnt++;
    if ({done_o, busy_o, d_ready_o, match_cnt_o} !== {3'b100, 8'd2}) begin
      miss_cnt++;
      $display("FAIL target_done: actual done,busy,ready=%b cnt=%0d required 100 cnt=2",
               {done_o, busy_o, d_ready_o}, match_cnt_o);
    end
    vec_cnt++;
    if (match_o !== 1'b0) begin
      miss_cnt++;
      $display("FAIL target_match_after: actual=%b required=0", match_o);
    end
    d_valid_i = 1'b0;
    tick();
    #1;
    vec_cnt++;
    if ({done_o, busy_o} !== 2'b00) begin
      miss_cnt++;
      $display("FAIL target_idle: actual done,busy=%b required=00", {done_o, busy_o});
    end
  endtask

  task automatic test_bad_len();
    logic [3:0] lens [2];
    lens[0] = 4'd0;
    lens[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      do_start(8'b0000_0101, lens[k], 1'b1, 8'd0);
      vec_cnt++;
      if ({done_o, err_o, d_ready_o, busy_o, match_cnt_o} !== {4'b1100, 8'd0}) begin
        miss_cnt++;
        $display("FAIL bad_len%0d_done: actual done,err,ready,busy=%b cnt=%0d required 1100 cnt=0",
                 lens[k], {done_o, err_o, d_ready_o, busy_o}, match_cnt_o);
      end
      tick();
      #1;
      vec_cnt++;
      if ({done_o, err_o, d_ready_o} !== 3'b010) begin
        miss_cnt++;
        $display("FAIL bad_len%0d_after: actual done,err,ready=%b required=010",
                 lens[k], {done_o, err_o, d_ready_o});
      end
    end
    do_start(8'b0000_0101, 4'd3, 1'b1, 8'd0);
    vec_cnt++;
    if ({err_o, busy_o} !== 2'b01) begin
      miss_cnt++;
      $display("FAIL legal_clears_err: actual err,busy=%b required=01", {err_o, busy_o});
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    tick();
  endtask

  // Bits 1,0,1 with two invalid cycles between them; config changes mid-run.
  task automatic test_gaps();
    logic [2:0] bits;
    bits = 3'b101;
    do_start(8'b0000_0101, 4'd3, 1'b1, 8'd0);
    cfg_pattern_i = 8'd0;
    cfg_len_i     = 4'd1;
    cfg_target_i  = 8'd1;
    tick();
    for (int i = 0; i < 3; i++) begin
      d_i       = bits[2-i];
      d_valid_i = 1'b1;
      #1;
      vec_cnt++;
      if (match_o !== (i == 2)) begin
        miss_cnt++;
        $display("FAIL gap_xfer%0d: actual=%b required=%b", i + 1, match_o, (i == 2));
      end
      tick();
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          d_valid_i = 1'b0;
          d_i       = ~d_i;
          #1;
          vec_cnt++;
          if (match_o !== 1'b0) begin
            miss_cnt++;
            $display("FAIL gap_idle%0d_%0d: actual=%b required=0", i + 1, g, match_o);
          end
          tick();
        end
      end
    end
    d_valid_i = 1'b0;
    #1;
    vec_cnt++;
    if ({match_cnt_o, busy_o} !== {8'd1, 1'b1}) begin
      miss_cnt++;
      $display("FAIL gap_cnt: actual cnt=%0d busy=%b required cnt=1 busy=1",
               match_cnt_o, busy_o);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    logic [2:0] bits;
    bits = 3'b101;
    do_start(8'b0000_0101, 4'd3, 1'b1, 8'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      d_i       = bits[2-i];
      d_valid_i = 1'b1;
      tick();
    end
    d_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    vec_cnt++;
    if ({d_ready_o, match_o, busy_o, done_o, err_o, match_cnt_o} !== {5'b00000, 8'd0}) begin
      miss_cnt++;
      $display("FAIL async_reset: actual flags=%b cnt=%0d required 00000 cnt=0",
               {d_ready_o, match_o, busy_o, done_o, err_o}, match_cnt_o);
    end
    d_valid_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    #1;
    vec_cnt++;
    if (done_o !== 1'b0) begin
      miss_cnt++;
      $display("FAIL reset_no_done: actual=%b required=0", done_o);
    end
    do_start(8'b0000_0101, 4'd3, 1'b1, 8'd0);
    tick();
    d_i       = 1'b1;
    d_valid_i = 1'b1;
    #1;
    vec_cnt++;
    if ({match_o, match_cnt_o, d_ready_o} !== {1'b0, 8'd0, 1'b1}) begin
      miss_cnt++;
      $display("FAIL clean_restart: actual match=%b cnt=%0d ready=%b required 0 0 1",
               match_o, match_cnt_o, d_ready_o);
    end
    tick();
    d_valid_i = 1'b0;
    abort_i   = 1'b1;
    tick();
    abort_i   = 1'b0;
    tick();
  endtask

  initial begin
    vec_cnt       = 0;
    miss_cnt      = 0;
    rst_ni        = 1'b0;
    cfg_pattern_i = 8'd0;
    cfg_len_i     = 4'd0;
    cfg_overlap_i = 1'b0;
    cfg_target_i  = 8'd0;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    d_i           = 1'b0;
    d_valid_i     = 1'b0;
    test_reset();
    #10;
    rst_ni = 1'b1;
    tick();
    test_stream(1'b1, 8'b0010_1001, 8'd3);
    test_stream(1'b0, 8'b0010_0001, 8'd2);
    test_target();
    test_bad_len();
    test_gaps();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
